// File: rtl/seq_slice_multiplier.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around one shared
// SLICE x SLICE combinational multiplier. One slice pair is multiplied per
// cycle and the partial products are shift-accumulated into the result.
module seq_slice_multiplier #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [SLICE-1:0]     mul_a,
    output logic [SLICE-1:0]     mul_b,
    input  logic [2*SLICE-1:0]   mul_p
);

    localparam int unsigned NS = (WIDTH + SLICE - 1) / SLICE;
    // Operands are padded to a whole number of slices; the top slice is zero-extended.
    localparam int unsigned PW = NS * SLICE;
    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NS - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [PW-1:0]   r_a;
    logic [PW-1:0]   r_b;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_result;
    logic [IW-1:0]   r_i;
    logic [IW-1:0]   r_j;
    logic [AW-1:0]   w_pp;
    logic [AW-1:0]   w_sum;
    logic            w_last;

    assign result = r_result;
    assign w_last = (r_i == LAST) && (r_j == LAST);
    // Partial product weighted by the combined slice position; truncation is
    // harmless because the true sum never exceeds (2^WIDTH-1)^2.
    assign w_pp   = AW'(mul_p) << (SLICE * (32'(r_i) + 32'(r_j)));
    assign w_sum  = r_acc + w_pp;

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and status / shared-multiplier outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        mul_a        = '0;
        mul_b        = '0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StMul;
                end
            end
            StMul: begin
                busy  = 1'b1;
                mul_a = r_a[32'(r_i) * SLICE +: SLICE];
                mul_b = r_b[32'(r_j) * SLICE +: SLICE];
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Operand latch, slice-pair counters, accumulator and result register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_i      <= '0;
            r_j      <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a   <= PW'(in1);
                        r_b   <= PW'(in2);
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                StMul: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_result <= w_sum;
                        r_i      <= '0;
                        r_j      <= '0;
                    end else if (r_j == LAST) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_slice_multiplier.sv
// Directed self-checking bench for seq_slice_multiplier (WIDTH=8, SLICE=3).
module tb_seq_slice_multiplier;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [2:0]  mul_a;
    logic [2:0]  mul_b;
    logic [5:0]  mul_p;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        scramble;
    } vec_t;

    vec_t vecs[9];

    seq_slice_multiplier #(.WIDTH(8), .SLICE(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .busy   (busy),
        .done   (done),
        .result (result),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_p  (mul_p)
    );

    // The shared small multiplier lives outside the controller.
    assign mul_p = mul_a * mul_b;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One full operation: pulse start, follow the slice trace, check latency/result.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                         input logic scramble);
        int         cycles;
        int         busy_cnt;
        bit         seen;
        logic [7:0] ea;
        logic [7:0] eb;
        @(negedge clock);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        cycles   = 1;
        busy_cnt = 0;
        seen     = 0;
        while (cycles <= 40) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                break;
            end
            if (cycles <= 9) begin
                ea = (a >> (3 * ((cycles - 1) / 3))) & 8'h07;
                eb = (b >> (3 * ((cycles - 1) % 3))) & 8'h07;
                check($sformatf("mul_a[%0d] %h*%h", cycles - 1, a, b), 32'(mul_a), 32'(ea));
                check($sformatf("mul_b[%0d] %h*%h", cycles - 1, a, b), 32'(mul_b), 32'(eb));
            end
            if (scramble && cycles == 3) begin
                in1 = ~a;
                in2 = ~b;
            end
            @(negedge clock);
            cycles++;
        end
        check($sformatf("done_seen %h*%h", a, b), 32'(seen), 32'd1);
        check($sformatf("latency %h*%h", a, b), 32'(cycles), 32'd10);
        check($sformatf("result %h*%h", a, b), 32'(result), 32'(exp));
        check($sformatf("busy_cycles %h*%h", a, b), 32'(busy_cnt), 32'd10);
        @(negedge clock);
        check($sformatf("done_after %h*%h", a, b), 32'(done), 32'd0);
        check($sformatf("busy_after %h*%h", a, b), 32'(busy), 32'd0);
        check($sformatf("result_hold %h*%h", a, b), 32'(result), 32'(exp));
    endtask

    initial begin
        int n_done;
        int last_t;

        vecs[0] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01, scramble: 1'b0};
        vecs[1] = '{a: 8'hA5, b: 8'h3C, p: 16'd9900, scramble: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'hB7, p: 16'd0,    scramble: 1'b0};
        vecs[3] = '{a: 8'h01, b: 8'h01, p: 16'd1,    scramble: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h02, p: 16'h0100, scramble: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'h01, p: 16'h00FF, scramble: 1'b0};
        vecs[6] = '{a: 8'hC0, b: 8'hC0, p: 16'h9000, scramble: 1'b0};
        vecs[7] = '{a: 8'h12, b: 8'h34, p: 16'd936,  scramble: 1'b1};
        vecs[8] = '{a: 8'h40, b: 8'h07, p: 16'h01C0, scramble: 1'b0};

        reset = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        foreach (vecs[k]) begin
            do_op(vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].scramble);
        end

        // start held high: a done every 11 cycles, result 6 each time.
        in1    = 8'd2;
        in2    = 8'd3;
        start  = 1'b1;
        n_done = 0;
        last_t = 0;
        for (int t = 1; t <= 43; t++) begin
            @(negedge clock);
            if (done) begin
                n_done++;
                check($sformatf("hold_result t=%0d", t), 32'(result), 32'd6);
                if (last_t == 0) check("hold_first", 32'(t), 32'd10);
                else check($sformatf("hold_spacing t=%0d", t), 32'(t - last_t), 32'd11);
                last_t = t;
            end
        end
        start = 1'b0;
        check("hold_pulses", 32'(n_done), 32'd4);
        n_done = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("hold_no_extra", 32'(n_done), 32'd0);

        // Reset during the 5th MUL cycle aborts with no done pulse.
        @(negedge clock);
        in1   = 8'hFF;
        in2   = 8'hFF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_mul_a", 32'(mul_a), 32'd0);
        reset  = 1'b0;
        start  = 1'b0;
        n_done = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clock);
            if (done || busy) n_done++;
        end
        check("abort_quiet", 32'(n_done), 32'd0);
        do_op(8'd7, 8'd9, 16'd63, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
